// File: rtl/sorter_pkg.sv
// Shared definitions for the sorter datapath: default frame geometry,
// loader FSM states and the pad value used to close partial frames.
package sorter_pkg;

  localparam int unsigned SORT_N_ELEM = 8;
  localparam int unsigned SORT_WIDTH  = 8;

  typedef enum logic {
    LD_FILL = 1'b0,
    LD_HOLD = 1'b1
  } loader_state_t;

  // All-ones sorts to the top, so padded slots never displace real data.
  localparam logic [SORT_WIDTH-1:0] PAD_VALUE = '1;

endpackage : sorter_pkg

// File: rtl/sort_frame_loader_if.sv
// Stream-in / frame-out bundle of the frame loader.
//   in_data/in_valid/in_ready : element stream into the loader
//   flush                     : abort (or, with padding, close) a partial frame
//   frame_data/frame_valid/frame_ready : packed frame handoff to the sorter
//   fill_count                : elements captured in the current/held frame
// slave = the loader, master = upstream source + sorter side.
interface sort_frame_loader_if
  import sorter_pkg::*;
#(
  parameter int unsigned N_ELEM = SORT_N_ELEM,
  parameter int unsigned WIDTH  = SORT_WIDTH
);
  localparam int unsigned CNT_W = $clog2(N_ELEM);

  logic [WIDTH-1:0]        in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [N_ELEM*WIDTH-1:0] frame_data;
  logic                    frame_valid;
  logic                    frame_ready;
  logic [CNT_W:0]          fill_count;

  modport master (
    output in_data, in_valid, flush, frame_ready,
    input  in_ready, frame_data, frame_valid, fill_count
  );

  modport slave (
    input  in_data, in_valid, flush, frame_ready,
    output in_ready, frame_data, frame_valid, fill_count
  );

endinterface : sort_frame_loader_if

// File: rtl/sort_frame_loader.sv
// Frame loader feeding the odd-even sorter: gathers N_ELEM words from a
// valid/ready stream into one packed frame, holds it until the sorter takes
// it, then refills.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - sort_frame_loader_if.slave (stream in, frame out, fill_count)
// Optional build macro SORT_LOADER_PAD_EN: flush of a non-empty partial frame
// pads the remaining slots with all-ones and hands the frame over instead of
// discarding it.
module sort_frame_loader
  import sorter_pkg::*;
#(
  parameter int unsigned N_ELEM = SORT_N_ELEM,
  parameter int unsigned WIDTH  = SORT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  sort_frame_loader_if.slave  bus
);

  localparam int unsigned CNT_W  = $clog2(N_ELEM);
  localparam int unsigned FILL_W = CNT_W + 1;
  localparam logic [FILL_W-1:0] LAST_IDX = FILL_W'(N_ELEM - 1);
`ifdef SORT_LOADER_PAD_EN
  localparam logic [WIDTH-1:0] L_PAD = '1;
`endif

  loader_state_t               r_state;
  loader_state_t               w_state_nxt;
  logic                        r_in_ready;
  logic                        r_frame_valid;
  logic                        w_in_ready_nxt;
  logic                        w_frame_valid_nxt;
  logic [FILL_W-1:0]           r_count;
  logic [N_ELEM-1:0][WIDTH-1:0] r_frame;

  logic w_accept;
  logic w_flush_fill;
  logic w_release;

  // flush wins over a simultaneous element; flush of an empty frame is a no-op.
  assign w_accept     = (r_state == LD_FILL) && bus.in_valid && !bus.flush;
  assign w_flush_fill = (r_state == LD_FILL) && bus.flush && (r_count != '0);
  // In HOLD, frame_ready delivers and a lone flush discards; both return to FILL.
  assign w_release    = (r_state == LD_HOLD) && (bus.frame_ready || bus.flush);

  // State register; handshake outputs registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= LD_FILL;
      r_in_ready    <= 1'b1;
      r_frame_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_in_ready    <= w_in_ready_nxt;
      r_frame_valid <= w_frame_valid_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LD_FILL: begin
        if (w_accept && (r_count == LAST_IDX)) begin
          w_state_nxt = LD_HOLD;
        end
`ifdef SORT_LOADER_PAD_EN
        if (w_flush_fill) begin
          w_state_nxt = LD_HOLD;
        end
`endif
      end
      LD_HOLD: begin
        if (w_release) begin
          w_state_nxt = LD_FILL;
        end
      end
      default: w_state_nxt = LD_FILL;
    endcase
  end

  // Output decode of the upcoming state, so the registered flags track r_state.
  always_comb begin
    w_in_ready_nxt    = 1'b0;
    w_frame_valid_nxt = 1'b0;
    if (w_state_nxt == LD_FILL) begin
      w_in_ready_nxt = 1'b1;
    end else begin
      w_frame_valid_nxt = 1'b1;
    end
  end

  // Element bank and fill counter; frame contents persist until overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_frame <= '0;
    end else begin
      if (w_accept) begin
        r_frame[r_count[CNT_W-1:0]] <= bus.in_data;
        r_count                     <= r_count + FILL_W'(1);
      end else if (w_flush_fill) begin
`ifdef SORT_LOADER_PAD_EN
        // Pad unfilled slots; fill_count keeps the true captured count.
        for (int unsigned i = 0; i < N_ELEM; i++) begin
          if (FILL_W'(i) >= r_count) begin
            r_frame[i] <= L_PAD;
          end
        end
`else
        r_count <= '0;
`endif
      end else if (w_release) begin
        r_count <= '0;
      end
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_data  = r_frame;
  assign bus.fill_count  = r_count;

endmodule : sort_frame_loader

// File: tb/tb_sort_frame_loader.sv
// Self-checking bench for sort_frame_loader (N_ELEM=8, WIDTH=8).
// A frame-level reference model is compared with the DUT every cycle, plus
// literal expectations for the directed scenarios. Honors SORT_LOADER_PAD_EN.
module tb_sort_frame_loader;
  import sorter_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned W  = 8;
  localparam int unsigned FW = $clog2(N) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  bit   chk_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  sort_frame_loader_if #(.N_ELEM(N), .WIDTH(W)) bus ();

  sort_frame_loader #(.N_ELEM(N), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: a frame buffer that is either collecting or holding.
  bit             m_hold;
  int             m_cnt;
  logic [W-1:0]   m_elem [N];
  int             m_delivered;

  function automatic logic [N*W-1:0] model_frame();
    logic [N*W-1:0] f;
    f = '0;
    for (int i = 0; i < N; i++) f[i*W +: W] = m_elem[i];
    return f;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold = 1'b0;
      m_cnt  = 0;
      for (int i = 0; i < N; i++) m_elem[i] = '0;
    end else if (!m_hold) begin
      if (bus.flush) begin
`ifdef SORT_LOADER_PAD_EN
        if (m_cnt > 0) begin
          for (int i = m_cnt; i < N; i++) m_elem[i] = '1;
          m_hold = 1'b1;
        end
`else
        m_cnt = 0;
`endif
      end else if (bus.in_valid) begin
        m_elem[m_cnt] = bus.in_data;
        m_cnt++;
        if (m_cnt == N) m_hold = 1'b1;
      end
    end else if (bus.frame_ready || bus.flush) begin
      if (bus.frame_ready) m_delivered++;
      m_hold = 1'b0;
      m_cnt  = 0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_in_ready",    64'(bus.in_ready),    64'(!m_hold));
      chk("cyc_frame_valid", 64'(bus.frame_valid), 64'(m_hold));
      chk("cyc_fill_count",  64'(bus.fill_count),  64'(m_cnt));
      chk("cyc_frame_data",  64'(bus.frame_data),  64'(model_frame()));
    end
  end

  task automatic idle();
    bus.in_valid    = 1'b0;
    bus.flush       = 1'b0;
    bus.frame_ready = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic handoff();
    bus.frame_ready = 1'b1;
    @(negedge clk);
    bus.frame_ready = 1'b0;
  endtask

  int rises [$];

  initial begin
    m_delivered  = 0;
    bus.in_data  = '0;
    idle();

    // Reset state.
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    chk("rst_frame_data",  64'(bus.frame_data),  64'h0);
    chk("rst_fill_count",  64'(bus.fill_count),  64'd0);
    chk("rst_frame_valid", 64'(bus.frame_valid), 64'd0);
    chk("rst_in_ready",    64'(bus.in_ready),    64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal back-to-back fill 0x11..0x88.
    for (int i = 1; i <= 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'(i * 17);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("fill_valid", 64'(bus.frame_valid), 64'd1);
    chk("fill_data",  64'(bus.frame_data),  64'h8877665544332211);
    chk("fill_count", 64'(bus.fill_count),  64'd8);
    chk("fill_ready", 64'(bus.in_ready),    64'd0);
    chk("model_fill_data", model_frame(), 64'h8877665544332211);

    // Backpressure: input ignored while holding.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    repeat (5) @(negedge clk);
    chk("bp_data",  64'(bus.frame_data), 64'h8877665544332211);
    chk("bp_ready", 64'(bus.in_ready),   64'd0);
    bus.in_valid = 1'b0;
    handoff();
    chk("bp_rel_ready", 64'(bus.in_ready),    64'd1);
    chk("bp_rel_count", 64'(bus.fill_count),  64'd0);
    chk("bp_rel_valid", 64'(bus.frame_valid), 64'd0);

    // Gapped input.
    for (int i = 0; i < 8; i++) begin
      push(W'(8'h31 + i));
      bus.in_data = 8'hEE;
      if (i < 7) chk("gap_no_valid", 64'(bus.frame_valid), 64'd0);
      @(negedge clk);
    end
    chk("gap_valid", 64'(bus.frame_valid), 64'd1);
    chk("gap_data",  64'(bus.frame_data),  64'h3837363534333231);
    chk("gap_count", 64'(bus.fill_count),  64'd8);
    handoff();

    // Flush with a simultaneous element.
    push(8'h01);
    push(8'h02);
    push(8'h03);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h04;
    bus.flush    = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
`ifdef SORT_LOADER_PAD_EN
    chk("pad_valid", 64'(bus.frame_valid), 64'd1);
    chk("pad_data",  64'(bus.frame_data),  64'hFFFFFFFFFF030201);
    chk("pad_count", 64'(bus.fill_count),  64'd3);
    chk("model_pad_data", model_frame(), 64'hFFFFFFFFFF030201);
    handoff();
`else
    chk("flush_count", 64'(bus.fill_count),  64'd0);
    chk("flush_valid", 64'(bus.frame_valid), 64'd0);
    chk("flush_ready", 64'(bus.in_ready),    64'd1);
    for (int i = 0; i < 8; i++) push(W'(8'hA0 + i));
    chk("post_flush_valid", 64'(bus.frame_valid), 64'd1);
    chk("post_flush_data",  64'(bus.frame_data),  64'hA7A6A5A4A3A2A1A0);
    chk("model_post_flush", model_frame(), 64'hA7A6A5A4A3A2A1A0);
    handoff();
`endif
    // Flush on an empty frame does nothing.
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_empty_ready", 64'(bus.in_ready),    64'd1);
    chk("flush_empty_valid", 64'(bus.frame_valid), 64'd0);

    // Asynchronous reset mid-fill.
    for (int i = 0; i < 5; i++) push(W'(8'h51 + i));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_frame_data",  64'(bus.frame_data),  64'h0);
    chk("arst_fill_count",  64'(bus.fill_count),  64'd0);
    chk("arst_frame_valid", 64'(bus.frame_valid), 64'd0);
    chk("arst_in_ready",    64'(bus.in_ready),    64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Streaming with frame_ready tied high; flush during HOLD still delivers.
    bus.frame_ready = 1'b1;
    bus.in_valid    = 1'b1;
    for (int c = 0; c < 50; c++) begin
      bus.in_data = W'($urandom);
      bus.flush   = bus.frame_valid;
      if (bus.frame_valid) rises.push_back(c);
      @(negedge clk);
    end
    idle();
    chk("stream_pulses", 64'(rises.size() >= 4), 64'd1);
    for (int k = 1; k < rises.size(); k++)
      chk("stream_period", 64'(rises[k] - rises[k-1]), 64'd9);
    @(negedge clk);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid    = ($urandom_range(0, 3) != 0);
      bus.in_data     = W'($urandom);
      bus.flush       = ($urandom_range(0, 19) == 0);
      bus.frame_ready = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    idle();
    @(negedge clk);
    chk("rand_frames_seen", 64'(m_delivered > 20), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sort_frame_loader
